alu_pipe_arbiter: RTL and testbench

- Shares one fixed-latency pipelined arithmetic datapath (four W-bit operands a/b/c/d in, one W-bit result F out) between NREQ requesters.
- Arbitrates issue slots, drives the pipeline inputs, and tracks each in-flight operation's requester ID through a LAT-deep tag pipe.
- Routes each emerging result back to its requester.
- Sits between the requester logic and the arithmetic pipeline.

---
 rtl/alu_pipe_arbiter_if.sv | 33 +++
 rtl/alu_pipe_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_pipe_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_arbiter_if.sv
// Requester, pipeline and response bundle for alu_pipe_arbiter.
// master = requester/datapath side, slave = arbiter.
interface alu_pipe_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 10
);
    logic              en;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ*W-1:0] op_c;
    logic [NREQ*W-1:0] op_d;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      pipe_a;
    logic [W-1:0]      pipe_b;
    logic [W-1:0]      pipe_c;
    logic [W-1:0]      pipe_d;
    logic              pipe_vld;
    logic [W-1:0]      pipe_f;
    logic [NREQ-1:0]   rsp_vld;
    logic [W-1:0]      rsp_data;
    logic              busy;

    modport master (
        output en, req, op_a, op_b, op_c, op_d, pipe_f,
        input  gnt, pipe_a, pipe_b, pipe_c, pipe_d, pipe_vld, rsp_vld, rsp_data, busy
    );

    modport slave (
        input  en, req, op_a, op_b, op_c, op_d, pipe_f,
        output gnt, pipe_a, pipe_b, pipe_c, pipe_d, pipe_vld, rsp_vld, rsp_data, busy
    );
endinterface

// File: rtl/alu_pipe_arbiter.sv
// Shares one LAT-deep arithmetic pipe among NREQ requesters; ALU_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: pipe_vld 1 cycle after the grant edge, rsp_vld LAT+1 cycles after it.
// Backpressure: requesters hold req until gnt; en=0 stops new grants while in-flight ops drain.
module alu_pipe_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 10,
    parameter int LAT  = 4
) (
    input  logic              clk1,
    input  logic              rst,
    alu_pipe_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LAT + 2);

    logic [NREQ-1:0]          gnt_c;
    logic [IDW-1:0]           gnt_id;
    logic                     xfer;

    logic [W-1:0]             pa_q, pb_q, pc_q, pd_q;
    logic                     pvld_q;
    logic [LAT-1:0]           tag_vld;
    logic [LAT-1:0][IDW-1:0]  tag_id;
    logic [NREQ-1:0]          rsp_vld_q;
    logic [W-1:0]             rsp_data_q;
    logic [CW-1:0]            cnt;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]           ptr;
    int                       idx;
`endif

    always_comb begin
        gnt_c  = '0;
        gnt_id = '0;
        xfer   = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
        idx    = 0;
`endif
        if (!rst && bus.en) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (bus.req[IDW'(i)]) begin
                    gnt_id = IDW'(i);
                    xfer   = 1'b1;
                end
            end
`else
            // Scan farthest-first so the requester nearest after ptr is the last writer.
            for (int k = NREQ; k >= 1; k--) begin
                idx = (int'(ptr) + k) % NREQ;
                if (bus.req[IDW'(idx)]) begin
                    gnt_id = IDW'(idx);
                    xfer   = 1'b1;
                end
            end
`endif
            if (xfer) gnt_c[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pa_q       <= '0;
            pb_q       <= '0;
            pc_q       <= '0;
            pd_q       <= '0;
            pvld_q     <= 1'b0;
            tag_vld    <= '0;
            tag_id     <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            cnt        <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr        <= IDW'(NREQ - 1);
`endif
        end else begin
            pvld_q <= xfer;
            if (xfer) begin
                pa_q <= bus.op_a[int'(gnt_id) * W +: W];
                pb_q <= bus.op_b[int'(gnt_id) * W +: W];
                pc_q <= bus.op_c[int'(gnt_id) * W +: W];
                pd_q <= bus.op_d[int'(gnt_id) * W +: W];
`ifndef ALU_ARB_FIXED_PRIO_EN
                ptr  <= gnt_id;
`endif
            end

            // Stage 0 lines up with pipe_vld, stage LAT-1 with pipe_f.
            for (int k = LAT - 1; k >= 1; k--) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            tag_vld[0] <= xfer;
            tag_id[0]  <= gnt_id;

            if (tag_vld[LAT-1]) begin
                rsp_vld_q  <= NREQ'(1) << tag_id[LAT-1];
                rsp_data_q <= bus.pipe_f;
            end else begin
                rsp_vld_q  <= '0;
            end

            // An op retires once its response strobe has been presented.
            if (xfer && !(|rsp_vld_q)) begin
                if (cnt != CW'(LAT + 1)) cnt <= cnt + CW'(1);
            end else if (!xfer && (|rsp_vld_q)) begin
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.pipe_a   = pa_q;
    assign bus.pipe_b   = pb_q;
    assign bus.pipe_c   = pc_q;
    assign bus.pipe_d   = pd_q;
    assign bus.pipe_vld = pvld_q;
    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.busy     = (cnt != '0);
endmodule

// File: tb/tb_alu_pipe_arbiter.sv
// Randomized plus directed bench for alu_pipe_arbiter against a queue-based reference model.
module tb_alu_pipe_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 10;
    localparam int LAT  = 4;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_pipe_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_pipe_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b,
                                           logic [W-1:0] c, logic [W-1:0] d);
        logic [W-1:0] r;
        r = ((a + b) + (c - d)) * d;
        return r;
    endfunction

    // Datapath stand-in: result presented LAT-1 edges after pipe_* appear.
    logic [W-1:0] ps [LAT-1] = '{default: '0};
    always @(posedge clk1) begin
        ps[0] <= alu_f(bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d);
        for (int k = 1; k < LAT - 1; k++) ps[k] <= ps[k-1];
    end
    assign bus.pipe_f = ps[LAT-2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected responses are a FIFO of (due cycle, id, value).
    typedef struct { int due; int id; logic [W-1:0] val; } pend_t;
    pend_t        q[$];
    int           cyc = 0;
    int           m_last = NREQ - 1;
    logic         m_pvld = 1'b0;
    logic [W-1:0] m_pa = '0, m_pb = '0, m_pc = '0, m_pd = '0;
    logic [NREQ-1:0] m_rvld = '0;
    logic [W-1:0] m_rdata = '0;

    function automatic int model_grant();
        if (rst || !bus.en) return -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (bus.req[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (bus.req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
        return -1;
    endfunction

    always @(posedge clk1 or posedge rst) begin
        int g;
        if (rst) begin
            q.delete();
            m_last = NREQ - 1;
            m_pvld = 1'b0;
            m_pa = '0; m_pb = '0; m_pc = '0; m_pd = '0;
            m_rvld = '0;
            m_rdata = '0;
        end else begin
            cyc++;
            m_rvld = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_rvld  = NREQ'(1) << q[0].id;
                m_rdata = q[0].val;
                void'(q.pop_front());
            end
            g = model_grant();
            m_pvld = (g >= 0);
            if (g >= 0) begin
                m_last = g;
                m_pa = bus.op_a[g*W +: W];
                m_pb = bus.op_b[g*W +: W];
                m_pc = bus.op_c[g*W +: W];
                m_pd = bus.op_d[g*W +: W];
                q.push_back('{due: cyc + LAT, id: g, val: alu_f(m_pa, m_pb, m_pc, m_pd)});
            end
        end
    end

    always @(negedge clk1) begin
        int g;
        g = model_grant();
        chk("gnt", 32'(bus.gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("pipe_vld", 32'(bus.pipe_vld), 32'(m_pvld));
        chk("pipe_a", 32'(bus.pipe_a), 32'(m_pa));
        chk("pipe_b", 32'(bus.pipe_b), 32'(m_pb));
        chk("pipe_c", 32'(bus.pipe_c), 32'(m_pc));
        chk("pipe_d", 32'(bus.pipe_d), 32'(m_pd));
        chk("rsp_vld", 32'(bus.rsp_vld), 32'(m_rvld));
        chk("rsp_data", 32'(bus.rsp_data), 32'(m_rdata));
        chk("busy", 32'(bus.busy), 32'((q.size() != 0) || (m_rvld != 0)));
        chk("count", 32'(dut.cnt), 32'(q.size() + ((m_rvld != 0) ? 1 : 0)));
    end

    // Response log and count high-water mark for the directed sections.
    logic [NREQ+W-1:0] rq[$];
    int cnt_max = 0;
    always @(negedge clk1) begin
        if (bus.rsp_vld != 0) rq.push_back({bus.rsp_vld, bus.rsp_data});
        if (int'(dut.cnt) > cnt_max) cnt_max = int'(dut.cnt);
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
        bus.op_a[i*W +: W] = W'(a);
        bus.op_b[i*W +: W] = W'(b);
        bus.op_c[i*W +: W] = W'(c);
        bus.op_d[i*W +: W] = W'(d);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk1);
            if (!bus.busy) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic wait_rsp(output logic [NREQ-1:0] v, output logic [W-1:0] d, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        v = '0;
        d = '0;
        while (!found && n < 20) begin
            @(negedge clk1);
            n++;
            if (bus.rsp_vld != 0) begin
                found = 1'b1;
                v = bus.rsp_vld;
                d = bus.rsp_data;
            end
        end
        if (!found) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] v;
        logic [W-1:0]    d;
        int              n;
        logic [NREQ-1:0] gseq [5];
        int exp_id [5] = '{0, 1, 2, 3, 0};
        int exp_v  [5] = '{75, 66, 112, 8, 75};

        bus.en = 1'b0;
        bus.req = '0;
        bus.op_a = '0; bus.op_b = '0; bus.op_c = '0; bus.op_d = '0;
        repeat (2) @(negedge clk1);
        chk("reset_pipe_vld", 32'(bus.pipe_vld), 0);
        chk("reset_rsp_vld", 32'(bus.rsp_vld), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        step();
        rst = 1'b0;
        bus.en = 1'b1;

        // Single op from requester 0.
        set_ops(0, 10, 12, 6, 3);
        bus.req = 4'b0001;
        @(negedge clk1);
        chk("single_gnt", 32'(bus.gnt), 32'b0001);
        step();
        bus.req = '0;
        @(negedge clk1);
        chk("single_pipe_vld", 32'(bus.pipe_vld), 1);
        wait_rsp(v, d, n);
        chk("single_latency", 32'(n), LAT);
        chk("single_rsp_vld", 32'(v), 32'b0001);
        chk("single_rsp_data", 32'(d), 75);
        @(negedge clk1);
        chk("single_busy_after", 32'(bus.busy), 0);
        drain();

        // Round robin from a fresh pointer.
        do_reset();
        set_ops(1, 10, 10, 5, 3);
        set_ops(2, 20, 11, 1, 4);
        set_ops(3, 1, 2, 3, 4);
        rq.delete();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk1);
            gseq[k] = bus.gnt;
            step();
        end
        bus.req = '0;
        drain();
        for (int k = 0; k < 5; k++) chk("rr_gnt", 32'(gseq[k]), 32'd1 << exp_id[k]);
        chk("rr_rsp_count", 32'(rq.size()), 5);
        for (int k = 0; k < 5 && k < rq.size(); k++) begin
            chk("rr_rsp_vld", 32'(rq[k][NREQ+W-1:W]), 32'd1 << exp_id[k]);
            chk("rr_rsp_data", 32'(rq[k][W-1:0]), 32'(exp_v[k]));
        end

        // Back-to-back issue from requester 2, then en gating with requester 1 waiting.
        cnt_max = 0;
        bus.req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            chk("b2b_gnt", 32'(bus.gnt), 32'b0100);
            step();
        end
        bus.en = 1'b0;
        bus.req = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk1);
            chk("en_off_gnt", 32'(bus.gnt), 0);
            chk("b2b_pipe_vld", 32'(bus.pipe_vld), (k == 0) ? 1 : 0);
            step();
        end
        bus.en = 1'b1;
        @(negedge clk1);
        chk("en_on_gnt", 32'(bus.gnt), 32'b0010);
        step();
        bus.req = '0;
        drain();
        chk("b2b_cnt_peak", 32'(cnt_max), 3);

        // Zero result and truncation passthrough.
        set_ops(0, 8, 15, 5, 0);
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        wait_rsp(v, d, n);
        chk("zero_rsp_data", 32'(d), 0);
        drain();
        set_ops(0, 30, 1, 2, 4);
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        wait_rsp(v, d, n);
        chk("trunc_rsp_data", 32'(d), 116);
        drain();

        // Reset with two ops in flight.
        set_ops(0, 1, 2, 3, 4);
        bus.req = 4'b0001;
        step();
        step();
        bus.req = '0;
        step();
        step();
        rst = 1'b1;
        bus.req = 4'b0001;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_pipe_a", 32'(bus.pipe_a), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        step();
        rst = 1'b0;
        bus.req = '0;
        rq.delete();
        repeat (LAT + 3) step();
        chk("rst_no_rsp", 32'(rq.size()), 0);
        bus.req = 4'b1010;
        @(negedge clk1);
        chk("rst_ptr_restart", 32'(bus.gnt), 32'b0010);
        step();
        bus.req = '0;
        drain();

`ifdef ALU_ARB_FIXED_PRIO_EN
        bus.req = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            chk("fp_gnt_low", 32'(bus.gnt), 32'b0010);
            step();
        end
        bus.req = 4'b0100;
        @(negedge clk1);
        chk("fp_gnt_after_drop", 32'(bus.gnt), 32'b0100);
        step();
        bus.req = '0;
        drain();
`endif

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            bus.req  = NREQ'($urandom);
            bus.en   = ($urandom_range(0, 7) != 0);
            bus.op_a = {$urandom, $urandom};
            bus.op_b = {$urandom, $urandom};
            bus.op_c = {$urandom, $urandom};
            bus.op_d = {$urandom, $urandom};
            rst      = ($urandom_range(0, 149) == 0);
            step();
            rst = 1'b0;
        end
        bus.req = '0;
        bus.en  = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
